// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage between EX and the register-file write port.
//   Runs RISC-V loads and stores one byte per cycle over an 8-bit RAM bus and
//   produces the registered writeback triple that feeds the register file.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid        instruction present from EX (accepted only in IDLE)
//   in_rd_enable    instruction writes rd
//   in_rd_addr      destination register
//   in_alu_result   writeback value for non-memory ops
//   in_mem_op       0 none,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW, 9-15 none
//   in_mem_addr     effective byte address
//   in_store_data   rs2 value for stores
//   mem_din         RAM read data, valid one cycle after mem_a
//   mem_a           RAM byte address
//   mem_dout        RAM write data
//   mem_wr          RAM write strobe
//   stall_req       upstream must hold its inputs while high
//   wb_enable       register write enable, one-cycle pulse
//   wb_addr         register write address (held when wb_enable=0)
//   wb_data         register write data (held when wb_enable=0)
module mem_access_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_rd_enable,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [3:0]            in_mem_op,
  input  logic [XLEN-1:0]       in_mem_addr,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [7:0]            mem_din,
  output logic [XLEN-1:0]       mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic                  stall_req,
  output logic                  wb_enable,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t                state, state_n;
  logic [2:0]            cnt, cnt_n;
  logic [XLEN-1:0]       base;
  logic [XLEN-1:0]       sdata;
  logic [XLEN-1:0]       ldata;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  rd_en;
  logic [3:0]            op;

  logic                  in_is_load, in_is_store, in_is_mem;
  logic                  op_is_load;
  logic [2:0]            nbytes;
  logic [2:0]            cnt_m1;
  logic [XLEN-1:0]       load_value;
  logic [XLEN-1:0]       cnt_ext;

  assign in_is_load  = (in_mem_op >= OP_LB) && (in_mem_op <= OP_LHU);
  assign in_is_store = (in_mem_op >= OP_SB) && (in_mem_op <= OP_SW);
  assign in_is_mem   = in_is_load || in_is_store;
  assign op_is_load  = (op >= OP_LB) && (op <= OP_LHU);
  assign cnt_m1      = cnt - 3'd1;
  assign cnt_ext     = {{(XLEN-3){1'b0}}, cnt};

  always_comb begin
    nbytes = 3'd4;
    case (op)
      OP_LB, OP_LBU, OP_SB: nbytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: nbytes = 3'd2;
      default:              nbytes = 3'd4;
    endcase
  end

  // Upper bytes of ldata are cleared on accept, so unsigned/word loads need
  // no extra masking here.
  always_comb begin
    load_value = ldata;
    case (op)
      OP_LB:   load_value = {{(XLEN-8){ldata[7]}}, ldata[7:0]};
      OP_LH:   load_value = {{(XLEN-16){ldata[15]}}, ldata[15:0]};
      default: load_value = ldata;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (in_valid && in_is_mem) begin
          state_n = in_is_load ? LOAD : STORE;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        if (cnt == nbytes) state_n = DONE;
        else               cnt_n   = cnt + 3'd1;
      end
      STORE: begin
        if (cnt == nbytes - 3'd1) state_n = DONE;
        else                      cnt_n   = cnt + 3'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs depend only on registered state so no in_* -> mem_* path exists.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state)
      LOAD: begin
        if (cnt < nbytes) mem_a = base + cnt_ext;
      end
      STORE: begin
        mem_a    = base + cnt_ext;
        mem_dout = sdata[{cnt[1:0], 3'b000} +: 8];
        mem_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_req = !rst && (((state == IDLE) && in_valid && in_is_mem) ||
                              (state == LOAD) || (state == STORE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      sdata     <= '0;
      ldata     <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      op        <= '0;
      wb_enable <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wb_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_is_mem) begin
              base    <= in_mem_addr;
              sdata   <= in_store_data;
              rd_addr <= in_rd_addr;
              rd_en   <= in_rd_enable;
              op      <= in_mem_op;
              ldata   <= '0;
            end else if (in_rd_enable && (in_rd_addr != '0)) begin
              wb_enable <= 1'b1;
              wb_addr   <= in_rd_addr;
              wb_data   <= in_alu_result;
            end
          end
        end
        LOAD: begin
          // mem_din lags mem_a by one cycle, so count k carries byte k-1.
          if (cnt != '0) ldata[{cnt_m1[1:0], 3'b000} +: 8] <= mem_din;
        end
        DONE: begin
          if (op_is_load && rd_en && (rd_addr != '0)) begin
            wb_enable <= 1'b1;
            wb_addr   <= rd_addr;
            wb_data   <= load_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_rd_enable;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_alu_result;
  logic [3:0]  in_mem_op;
  logic [31:0] in_mem_addr;
  logic [31:0] in_store_data;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        stall_req;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  logic [4:0]  last_addr;
  logic [31:0] last_data;

  logic [7:0] ram     [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  mem_access_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rd_enable(in_rd_enable),
    .in_rd_addr(in_rd_addr), .in_alu_result(in_alu_result), .in_mem_op(in_mem_op),
    .in_mem_addr(in_mem_addr), .in_store_data(in_store_data), .mem_din(mem_din),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .stall_req(stall_req),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
  end

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 1;
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2;
    return 4;
  endfunction

  task automatic do_op(input logic [3:0] op, input logic rd_en, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] addr,
                       input logic [31:0] sdata);
    bit ld, st, wb_exp, en_now;
    int n, lat, stall_last, maxc;
    logic [31:0] w, exp;
    ld = (op >= 4'd1 && op <= 4'd5);
    st = (op >= 4'd6 && op <= 4'd8);
    n  = op_bytes(op);
    w  = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(addr + 32'(i));
    case (op)
      4'd1:    exp = {{24{w[7]}}, w[7:0]};
      4'd2:    exp = {{16{w[15]}}, w[15:0]};
      default: exp = w;
    endcase
    if (!ld && !st) exp = alu;
    wb_exp     = rd_en && (rd != 5'd0) && !st;
    lat        = ld ? n + 3 : (st ? -1 : 1);
    stall_last = ld ? n + 1 : (st ? n : -1);
    maxc       = (ld || st) ? n + 4 : 2;

    @(posedge clk); #1;
    in_valid = 1'b1; in_mem_op = op; in_rd_enable = rd_en; in_rd_addr = rd;
    in_alu_result = alu; in_mem_addr = addr; in_store_data = sdata;
    for (int c = 0; c <= maxc; c++) begin
      @(negedge clk);
      tests++;
      if (stall_req !== (c <= stall_last)) begin
        fails++;
        $display("FAIL stall op=%0d c=%0d got=%b exp=%b", op, c, stall_req, (c <= stall_last));
      end
      if ((ld || st) && c >= 1 && c <= n) begin
        tests++;
        if (mem_a !== addr + 32'(c - 1)) begin
          fails++;
          $display("FAIL mem_a op=%0d c=%0d got=%h exp=%h", op, c, mem_a, addr + 32'(c - 1));
        end
        tests++;
        if (mem_wr !== st) begin
          fails++;
          $display("FAIL mem_wr op=%0d c=%0d got=%b exp=%b", op, c, mem_wr, st);
        end
        if (st) begin
          tests++;
          if (mem_dout !== sdata[8*(c-1) +: 8]) begin
            fails++;
            $display("FAIL mem_dout c=%0d got=%h exp=%h", c, mem_dout, sdata[8*(c-1) +: 8]);
          end
        end
      end else begin
        tests++;
        if (mem_wr !== 1'b0) begin
          fails++;
          $display("FAIL mem_wr_idle op=%0d c=%0d got=%b exp=0", op, c, mem_wr);
        end
      end
      en_now = wb_exp && (c == lat);
      if (en_now) begin
        last_addr = rd;
        last_data = exp;
      end
      tests++;
      if (wb_enable !== en_now) begin
        fails++;
        $display("FAIL wb_enable op=%0d c=%0d got=%b exp=%b", op, c, wb_enable, en_now);
      end
      tests++;
      if (wb_addr !== last_addr || wb_data !== last_data) begin
        fails++;
        $display("FAIL wb_value op=%0d c=%0d got=%0d/%h exp=%0d/%h",
                 op, c, wb_addr, wb_data, last_addr, last_data);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (st) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = sdata[8*i +: 8];
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_mem_op = 4'd3; in_rd_enable = 1'b1;
    in_rd_addr = 5'd9; in_alu_result = 32'hDEAD; in_mem_addr = 32'h40; in_store_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL reset_wb_enable got=%b exp=0", wb_enable); end
    tests++; if (wb_addr !== 5'd0) begin fails++; $display("FAIL reset_wb_addr got=%0d exp=0", wb_addr); end
    tests++; if (wb_data !== 32'd0) begin fails++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    tests++; if (mem_a !== 32'd0) begin fails++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
    tests++; if (mem_dout !== 8'd0) begin fails++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
    tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    last_addr = '0; last_data = '0;
  endtask

  task automatic test_alu;
    do_op(4'd0, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0);
    do_op(4'd12, 1'b1, 5'd6, 32'hCAFE_0001, 32'h10, 32'h0);
    do_op(4'd0, 1'b0, 5'd7, 32'h5555_5555, 32'h0, 32'h0);
    do_op(4'd0, 1'b1, 5'd0, 32'h7777_7777, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++)
      do_op(4'd0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, 32'h0, 32'h0);
  endtask

  task automatic test_load;
    poke(32'h100, 8'h80);
    do_op(4'd1, 1'b1, 5'd3, 32'h0, 32'h100, 32'h0);
    do_op(4'd4, 1'b1, 5'd3, 32'h0, 32'h100, 32'h0);
    poke(32'h201, 8'h11); poke(32'h202, 8'h22); poke(32'h203, 8'h33); poke(32'h204, 8'h44);
    do_op(4'd3, 1'b1, 5'd7, 32'h0, 32'h201, 32'h0);
    poke(32'h300, 8'h34); poke(32'h301, 8'hF2);
    do_op(4'd2, 1'b1, 5'd8, 32'h0, 32'h300, 32'h0);
    do_op(4'd5, 1'b1, 5'd8, 32'h0, 32'h300, 32'h0);
  endtask

  task automatic test_store;
    do_op(4'd7, 1'b1, 5'd4, 32'h0, 32'hFFFF_FFFF, 32'h0000_BEEF);
    do_op(4'd5, 1'b1, 5'd9, 32'h0, 32'hFFFF_FFFF, 32'h0);
    do_op(4'd8, 1'b0, 5'd0, 32'h0, 32'h0000_0402, 32'h8765_4321);
    do_op(4'd3, 1'b1, 5'd10, 32'h0, 32'h0000_0402, 32'h0);
    do_op(4'd6, 1'b1, 5'd11, 32'h0, 32'h0000_0403, 32'h0000_00A5);
    do_op(4'd1, 1'b1, 5'd12, 32'h0, 32'h0000_0403, 32'h0);
  endtask

  task automatic test_rd_zero;
    do_op(4'd3, 1'b1, 5'd0, 32'h0, 32'h0000_0201, 32'h0);
    do_op(4'd1, 1'b0, 5'd13, 32'h0, 32'h0000_0100, 32'h0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    bit en_now;
    a = 32'h0000_0500;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mem_op = 4'd8; in_rd_enable = 1'b1; in_rd_addr = 5'd2;
    in_alu_result = '0; in_mem_addr = a; in_store_data = 32'hA1B2_C3D4;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      tests++;
      if (stall_req !== (c <= 4)) begin
        fails++;
        $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, stall_req, (c <= 4));
      end
      en_now = (c == 7);
      if (en_now) begin last_addr = 5'd14; last_data = 32'h0BAD_F00D; end
      tests++;
      if (wb_enable !== en_now) begin
        fails++;
        $display("FAIL b2b_wb_enable c=%0d got=%b exp=%b", c, wb_enable, en_now);
      end
      tests++;
      if (wb_addr !== last_addr || wb_data !== last_data) begin
        fails++;
        $display("FAIL b2b_wb_value c=%0d got=%0d/%h exp=%0d/%h", c, wb_addr, wb_data, last_addr, last_data);
      end
      @(posedge clk); #1;
      if (c < 6) begin
        in_valid = 1'b1; in_mem_op = 4'd0; in_rd_enable = 1'b1; in_rd_addr = 5'd14;
        in_alu_result = 32'h0BAD_F00D;
      end else begin
        in_valid = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = 8'(32'hA1B2_C3D4 >> (8*i));
    do_op(4'd3, 1'b1, 5'd15, 32'h0, a, 32'h0);
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] a;
    a = 32'h0000_0600;
    for (int i = 0; i < 4; i++) poke(a + 32'(i), 8'h10 + 8'(i));
    @(posedge clk); #1;
    in_valid = 1'b1; in_mem_op = 4'd8; in_rd_enable = 1'b1; in_rd_addr = 5'd3;
    in_mem_addr = a; in_store_data = 32'hFFEE_DDCC;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL midrst_stall got=%b exp=0", stall_req); end
    @(posedge clk); #1; rst = 1'b0;
    last_addr = '0; last_data = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL midrst_mem_wr c=%0d got=%b exp=0", c, mem_wr); end
      tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL midrst_wb_enable c=%0d got=%b exp=0", c, wb_enable); end
      tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL midrst_stall_after c=%0d got=%b exp=0", c, stall_req); end
      tests++; if (wb_data !== 32'd0) begin fails++; $display("FAIL midrst_wb_data c=%0d got=%h exp=0", c, wb_data); end
    end
    tests++;
    if (ram_rd(a + 32'd2) !== 8'h12 || ram_rd(a + 32'd3) !== 8'h13) begin
      fails++;
      $display("FAIL midrst_no_late_write got=%h%h exp=1312", ram_rd(a + 32'd3), ram_rd(a + 32'd2));
    end
    poke(a, 8'h10); poke(a + 32'd1, 8'h11);
    do_op(4'd3, 1'b1, 5'd16, 32'h0, a, 32'h0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                      : 32'h0000_0700 + 32'($urandom_range(0, 15));
      do_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 5'($urandom),
            $urandom, a, $urandom);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_mem_op = '0; in_rd_enable = 1'b0; in_rd_addr = '0;
    in_alu_result = '0; in_mem_addr = '0; in_store_data = '0; rst = 1'b1;
    last_addr = '0; last_data = '0;
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_rd_zero;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
